// File: rtl/cook_timer.sv
// BCD MM:SS countdown timer for the microwave: keypad entry while the magnetron is off, one-second
// countdown while it is on. Optional +30 s button is built when COOK_TIMER_ADD30_EN is defined.
module cook_timer #(
  parameter int unsigned TICK_DIV = 1000,
  parameter int unsigned PRE_W    = 10
) (
  input  logic       i_clk,
  input  logic       i_resetn,
  input  logic       i_mag_on,
  input  logic       i_clearn,
  input  logic       i_key_valid,
  input  logic [3:0] i_key_digit,
`ifdef COOK_TIMER_ADD30_EN
  input  logic       i_add30,
`endif
  output logic [3:0] o_min_tens,
  output logic [3:0] o_min_ones,
  output logic [3:0] o_sec_tens,
  output logic [3:0] o_sec_ones,
  output logic       o_timer_done,
  output logic       o_done_pulse,
  output logic       o_running
);

  localparam logic [PRE_W-1:0] PreLast = PRE_W'(TICK_DIV - 1);

  logic [3:0]       r_min_tens, r_min_ones, r_sec_tens, r_sec_ones;
  logic [PRE_W-1:0] r_pre;
  logic             r_done_pulse;

  logic             w_zero, w_count, w_tick, w_key;
  logic [15:0]      w_cur, w_dec, w_base, w_nxt;

  assign w_cur   = {r_min_tens, r_min_ones, r_sec_tens, r_sec_ones};
  assign w_zero  = (w_cur == 16'h0000);
  assign w_count = i_mag_on & ~w_zero;
  assign w_tick  = w_count & (r_pre == PreLast);
  assign w_key   = ~i_mag_on & i_key_valid & (i_key_digit <= 4'd9);

  // Borrow chain; seconds tens borrows from 0 to 5, entered tens above 5 just count down.
  always_comb begin
    w_dec = w_cur;
    if (r_sec_ones != 4'd0) begin
      w_dec[3:0] = r_sec_ones - 4'd1;
    end else begin
      w_dec[3:0] = 4'd9;
      if (r_sec_tens != 4'd0) begin
        w_dec[7:4] = r_sec_tens - 4'd1;
      end else begin
        w_dec[7:4] = 4'd5;
        if (r_min_ones != 4'd0) begin
          w_dec[11:8] = r_min_ones - 4'd1;
        end else begin
          w_dec[11:8]  = 4'd9;
          w_dec[15:12] = r_min_tens - 4'd1;
        end
      end
    end
  end

  always_comb begin
    w_base = w_cur;
    if (w_tick) begin
      w_base = w_dec;
    end else if (w_key) begin
      w_base = {r_min_ones, r_sec_tens, r_sec_ones, i_key_digit};
    end
  end

`ifdef COOK_TIMER_ADD30_EN
  logic [3:0] w_sum_tens;
  logic [3:0] w_tens_lim;

  assign w_sum_tens = w_base[7:4] + 4'd3;
  assign w_tens_lim = (w_base[7:4] > 4'd5) ? 4'd9 : 4'd5;

  // +30 s applied on top of the tick/key result; minute overflow saturates at 99:59.
  always_comb begin
    w_nxt = w_base;
    if (i_add30) begin
      if (w_sum_tens > w_tens_lim) begin
        w_nxt[7:4] = w_sum_tens - 4'd6;
        if (w_base[11:8] != 4'd9) begin
          w_nxt[11:8] = w_base[11:8] + 4'd1;
        end else if (w_base[15:12] != 4'd9) begin
          w_nxt[11:8]  = 4'd0;
          w_nxt[15:12] = w_base[15:12] + 4'd1;
        end else begin
          w_nxt = 16'h9959;
        end
      end else begin
        w_nxt[7:4] = w_sum_tens;
      end
    end
  end
`else
  assign w_nxt = w_base;
`endif

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_min_tens   <= 4'd0;
      r_min_ones   <= 4'd0;
      r_sec_tens   <= 4'd0;
      r_sec_ones   <= 4'd0;
      r_pre        <= '0;
      r_done_pulse <= 1'b0;
    end else if (!i_clearn) begin
      r_min_tens   <= 4'd0;
      r_min_ones   <= 4'd0;
      r_sec_tens   <= 4'd0;
      r_sec_ones   <= 4'd0;
      r_pre        <= '0;
      r_done_pulse <= 1'b0;
    end else begin
      {r_min_tens, r_min_ones, r_sec_tens, r_sec_ones} <= w_nxt;
      if (w_count) begin
        r_pre <= w_tick ? '0 : r_pre + PRE_W'(1);
      end else if (w_key) begin
        r_pre <= '0;
      end
      r_done_pulse <= w_tick & (w_nxt == 16'h0000);
    end
  end

  assign o_min_tens   = r_min_tens;
  assign o_min_ones   = r_min_ones;
  assign o_sec_tens   = r_sec_tens;
  assign o_sec_ones   = r_sec_ones;
  assign o_timer_done = w_zero;
  assign o_done_pulse = r_done_pulse;
  assign o_running    = w_count;

endmodule

// File: tb/tb_cook_timer.sv
// Scoreboard bench for cook_timer: a minutes/seconds integer model predicts every cycle's outputs,
// a negedge monitor compares. Define COOK_TIMER_ADD30_EN to also exercise the +30 s input.
module tb_cook_timer;

  localparam int TD = 4;

  logic       clk = 1'b0;
  logic       resetn;
  logic       mag_on, clearn, key_valid, add30;
  logic [3:0] key_digit;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic       timer_done, done_pulse, running;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int  mt, mo, st, so;
    bit  done, pulse, run;
  } exp_t;

  exp_t q[$];

  // Reference model: time as integer minutes/seconds, prescaler as a cycle count.
  int m_min, m_sec, m_pre;
  bit m_pulse;

  always #5 clk = ~clk;

  cook_timer #(
    .TICK_DIV(TD),
    .PRE_W   (3)
  ) dut (
    .i_clk       (clk),
    .i_resetn    (resetn),
    .i_mag_on    (mag_on),
    .i_clearn    (clearn),
    .i_key_valid (key_valid),
    .i_key_digit (key_digit),
`ifdef COOK_TIMER_ADD30_EN
    .i_add30     (add30),
`endif
    .o_min_tens  (min_tens),
    .o_min_ones  (min_ones),
    .o_sec_tens  (sec_tens),
    .o_sec_ones  (sec_ones),
    .o_timer_done(timer_done),
    .o_done_pulse(done_pulse),
    .o_running   (running)
  );

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    m_min = 0; m_sec = 0; m_pre = 0; m_pulse = 0;
  endtask

  // One clock edge of the model, using the inputs currently driven.
  task automatic model_edge();
    bit tick;
    int v, orig;
    tick = 0;
    if (!clearn) begin
      model_reset();
    end else begin
      if (mag_on && (m_min != 0 || m_sec != 0)) begin
        if (m_pre == TD - 1) begin
          m_pre = 0;
          tick  = 1;
        end else begin
          m_pre++;
        end
      end
      if (tick) begin
        if (m_sec > 0) m_sec--;
        else begin
          m_sec = 59;
          m_min--;
        end
      end else if (!mag_on && key_valid && key_digit <= 9) begin
        v     = ((m_min * 100 + m_sec) * 10 + int'(key_digit)) % 10000;
        m_min = v / 100;
        m_sec = v % 100;
        m_pre = 0;
      end
`ifdef COOK_TIMER_ADD30_EN
      if (add30) begin
        orig  = m_sec;
        m_sec = orig + 30;
        if (m_sec >= ((orig >= 60) ? 100 : 60)) begin
          m_sec -= 60;
          m_min++;
        end
        if (m_min > 99) begin
          m_min = 99;
          m_sec = 59;
        end
      end
`endif
      m_pulse = tick && m_min == 0 && m_sec == 0;
    end
  endtask

  task automatic push_exp();
    exp_t e;
    e.mt    = m_min / 10;
    e.mo    = m_min % 10;
    e.st    = m_sec / 10;
    e.so    = m_sec % 10;
    e.done  = (m_min == 0 && m_sec == 0);
    e.pulse = m_pulse;
    e.run   = mag_on && !e.done;
    q.push_back(e);
  endtask

  // Clock the previously driven inputs in, then drive the next inputs.
  task automatic step(input logic mag, input logic clr, input logic kv, input logic [3:0] kd,
                      input logic add);
    @(posedge clk);
    model_edge();
    #1;
    mag_on = mag; clearn = clr; key_valid = kv; key_digit = kd; add30 = add;
    push_exp();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
  endtask

  task automatic key(input logic [3:0] d);
    step(1'b0, 1'b1, 1'b1, d, 1'b0);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
  endtask

  task automatic clear();
    step(1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
  endtask

  // Monitor: outputs are compared mid-cycle against the scoreboard entry for that cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("min_tens",   int'(min_tens),   e.mt);
        chk("min_ones",   int'(min_ones),   e.mo);
        chk("sec_tens",   int'(sec_tens),   e.st);
        chk("sec_ones",   int'(sec_ones),   e.so);
        chk("timer_done", int'(timer_done), int'(e.done));
        chk("done_pulse", int'(done_pulse), int'(e.pulse));
        chk("running",    int'(running),    int'(e.run));
      end
    end
  end

  initial begin
    bit rmag;
    resetn = 1'b0; mag_on = 1'b0; clearn = 1'b1; key_valid = 1'b0; key_digit = 4'd0;
    add30 = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;

    idle(2);
    key(4'd1); key(4'd3); key(4'd0); key(4'd12); idle(2);

    clear(); key(4'd2); run(12); idle(2);

    clear(); key(4'd1); key(4'd0); key(4'd0);
    run(4); idle(10); run(5); idle(2);

    // Clear lands on the tick edge of a countdown from 00:45.
    clear(); key(4'd4); key(4'd5);
    run(3); step(1'b1, 1'b0, 1'b0, 4'd0, 1'b0); idle(3);

`ifdef COOK_TIMER_ADD30_EN
    clear(); key(4'd4); key(4'd5); step(1'b0, 1'b1, 1'b0, 4'd0, 1'b1); idle(2);
    clear(); key(4'd9); key(4'd9); key(4'd4); key(4'd5);
    step(1'b0, 1'b1, 1'b0, 4'd0, 1'b1); idle(2);
    clear(); key(4'd1); run(3); step(1'b1, 1'b1, 1'b0, 4'd0, 1'b1); run(4); idle(2);
`endif

    // Asynchronous reset in the middle of a countdown.
    clear(); key(4'd1); key(4'd0); key(4'd0); run(6);
    @(negedge clk);
    #1 resetn = 1'b0;
    #1;
    chk("async_digits", int'({min_tens, min_ones, sec_tens, sec_ones}), 0);
    chk("async_done",    int'(timer_done), 1);
    chk("async_pulse",   int'(done_pulse), 0);
    chk("async_running", int'(running),    0);
    model_reset();
    mag_on = 1'b0;
    @(posedge clk);
    #1 resetn = 1'b1;
    idle(2);

    rmag = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) rmag = ~rmag;
      step(rmag, ($urandom_range(0, 149) != 0), ($urandom_range(0, 2) == 0),
           4'($urandom_range(0, 15)),
`ifdef COOK_TIMER_ADD30_EN
           ($urandom_range(0, 24) == 0)
`else
           1'b0
`endif
           );
    end
    idle(2);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) chk("scoreboard_drain", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cook_timer.md
Name: cook_timer

Overview:
- BCD MM:SS countdown timer for the microwave. It is the counterpart of the magnetron control: it consumes mag_on and produces timer_done.
- Time is entered digit-by-digit from the keypad while the magnetron is off.
- The timer counts down one second per prescaler period while mag_on is high.
- timer_done is high whenever remaining time is zero; this keeps the magnetron from starting, or forces it off.

Parameters:
- TICK_DIV, 1000, clk cycles per 1-second tick; minimum 2.
- PRE_W, 10, prescaler width; must satisfy 2^PRE_W >= TICK_DIV.

Ports:
- clk  in  1  system clock, rising edge
- resetn  in  1  asynchronous active-low reset
- mag_on  in  1  magnetron state; high = counting enabled
- clearn  in  1  synchronous active-low clear of time and prescaler
- key_valid  in  1  one-cycle strobe, key_digit valid
- key_digit  in  4  BCD keypad digit 0-9
- min_tens  out  4  BCD minutes tens
- min_ones  out  4  BCD minutes ones
- sec_tens  out  4  BCD seconds tens (0-9 on entry)
- sec_ones  out  4  BCD seconds ones
- timer_done  out  1  level: high iff all four digits are zero
- done_pulse  out  1  one-cycle strobe when a countdown tick reaches 00:00
- running  out  1  high while mag_on is high and time is nonzero

Behaviour:
- Reset (resetn low, asynchronous): all digits 0, prescaler 0, done_pulse 0, timer_done 1, running 0.
- States:
  - IDLE: time is zero, no countdown has completed.
  - SET: time is nonzero, mag_on is low.
  - COUNT: time is nonzero, mag_on is high.
  - DONE: reached zero by countdown.
- timer_done is combinational from the digit registers (zero-compare). It is high in IDLE and DONE.
- Key entry:
  - Accepted only when mag_on is 0, key_valid is 1 and key_digit <= 9.
  - Shift left: min_tens<=min_ones, min_ones<=sec_tens, sec_tens<=sec_ones, sec_ones<=key_digit.
  - Accepted entry clears the prescaler. From DONE, an accepted entry starts from the current all-zero value.
  - Digits 10-15 are ignored.
- Entered values such as 0:90 are legal and count down through 0:89. No normalisation is applied.
- Prescaler:
  - Increments each cycle while mag_on=1 and time is nonzero.
  - At TICK_DIV-1 it wraps to 0 and issues an internal tick.
  - Holds its value while mag_on=0, so a pause keeps its phase.
- Tick, BCD decrement with borrow chain:
  - sec_ones 0 -> 9 with borrow.
  - sec_tens 0 -> 5 with borrow.
  - min_ones 0 -> 9 with borrow.
  - min_tens decrements by 1.
- Update latency: digits change on the edge after the prescaler reaches TICK_DIV-1. timer_done rises in the same cycle the digits become 0000.
- done_pulse is high for exactly the cycle after the tick edge that produced 0000. Clear or key entry never produces done_pulse.
- Priority, highest first: resetn, clearn, tick, key entry.
  - clearn low: digits 0, prescaler 0, done_pulse 0, state IDLE.
  - Key entry and tick cannot coincide, because entry requires mag_on=0.
- mag_on high with zero time: no count, prescaler held, running 0.
- Asynchronous reset mid-count returns everything to reset values immediately.

Optional Feature:
- Macro: COOK_TIMER_ADD30_EN
- With the macro: extra input port add30 (1 bit, one-cycle strobe).
  - Adds 30 seconds in BCD with carry: sec_tens+3. If the result is >5 (or >9 for entered values), subtract 6 and carry into minutes.
  - Saturates at 99:59.
  - Accepted in any state including COUNT.
  - Does not alter the prescaler and cannot raise done_pulse.
  - clearn has priority over add30. A tick in the same cycle applies the decrement first, then the +30.
- Without the macro: the port is absent and no add logic is generated.

Test Plan (TICK_DIV=4):
- Reset released, no stimulus -> digits 0000, timer_done=1, done_pulse=0, running=0.
- Keys 1,3,0 with mag_on=0 -> display 01:30, timer_done=0. Key value 12 ignored -> still 01:30.
- 00:02 loaded, mag_on=1 -> 00:01 after 4 cycles, 00:00 after 8 cycles. timer_done rises with 00:00, done_pulse high for 1 cycle, running falls.
- 01:00 loaded, mag_on=1 for 4 cycles -> 00:59. Drop mag_on for 10 cycles -> held at 00:59. Reassert mag_on -> 00:58 after 4 more cycles.
- Countdown at 00:45, clearn low for 1 cycle on the same cycle as a tick -> 00:00, done_pulse stays 0, prescaler 0.
- With COOK_TIMER_ADD30_EN: 00:45 + add30 -> 01:15. 99:45 + add30 -> 99:59.
